u_lsu_store_rmw_unit: RTL and testbench
=======================================

// Module: u_lsu_store_rmw_unit
// PURPOSE
//  Store side of the LSU data-memory path. Executes RV32I SB/SH/SW into the 128-bit-wide
//  data memory, which has no byte enables, by read-modify-write of the whole line.
//  It reads the addressed line, merges the store byte, half or word into its lane, and writes
//  the line back. Sits between the LSU store request and the Dmem port; the load selector
//  uses the same line-lane mapping.
// PARAMETERS
//  ADDR_W   default `DATA_MEM_WIDTH_BIT  byte address width
//  LINE_W   default `DATA_MEM_WIDTH (128)  Dmem line width, fixed 128 (16 byte lanes)
//  DATA_W   default `DATA_WIDTH (32)     store data width
// PORTS
//  clk            in   1         single clock, all state on rising edge
//  rst            in   1         synchronous, active-high reset
//  st_valid       in   1         store request valid
//  st_ready       out  1         unit idle, request accepted when st_valid&st_ready
//  sb / sh / sw   in   1 each    store size flags, exactly one set with st_valid
//  addr           in   ADDR_W    byte address of store
//  st_data        in   DATA_W    store data; SB uses [7:0], SH uses [15:0]
//  dmem_rd_en     out  1         line read strobe
//  dmem_addr      out  ADDR_W-4  line address = captured addr[ADDR_W-1:4]
//  dmem_rd_data   in   LINE_W    read line, valid the cycle after dmem_rd_en
//  dmem_wr_en     out  1         line write strobe
//  dmem_wr_data   out  LINE_W    merged line
//  st_done        out  1         1-cycle pulse: store finished (written or faulted)
//  st_misaligned  out  1         1-cycle pulse with st_done: request faulted, no write
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, capture regs=0, every output 0 except st_ready=1.
//    Reset in any state aborts the store. No dmem_wr_en after the reset edge.
//  - FSM states are IDLE, RD, MRG, WR, ERR. st_ready=1 only in IDLE.
//    st_valid in any other state is ignored and not queued.
//  - IDLE: on st_valid, capture addr, st_data and the size flags.
//    Fault condition: flag count != 1, or sh&addr[0], or sw&(addr[1:0]!=0).
//    Fault -> ERR. Otherwise -> RD.
//  - RD (T+1): dmem_rd_en=1, dmem_addr=line addr. Always -> MRG.
//  - MRG (T+2): sample dmem_rd_data and register the merged line. Always -> WR.
//    Merge: SB replaces bits [8*a+7 : 8*a], a=addr[3:0].
//    SH replaces [16*h+15 : 16*h], h=addr[3:1].
//    SW replaces [32*w+31 : 32*w], w=addr[3:2].
//    All other line bits pass through unchanged from dmem_rd_data.
//  - WR (T+3): dmem_wr_en=1, dmem_addr=line addr, dmem_wr_data=merged line, st_done=1.
//    -> IDLE.
//  - ERR (T+1): st_done=1, st_misaligned=1, dmem_rd_en=dmem_wr_en=0. -> IDLE.
//  - Latency: accept at T, write at T+3, st_ready again at T+4. Throughput is 1 store per 4 cycles.
//  - Back-to-back stores to the same line are hazard-free: each write completes before
//    the next accept, so the next read sees the prior write.
//  - dmem_addr holds the captured line addr in RD/MRG/WR, and is 0 in IDLE/ERR.
//    dmem_wr_data is 0 outside WR.
//  - Strobes and pulses are decoded from state. Each is high for exactly one cycle per store.
// TESTING
//  1. Hold rst 2 cycles -> st_ready=1, all other outputs 0.
//  2. SW addr=0x08, data=0xDEADBEEF, line=all 0x11 -> rd_en at T+1, wr_en at T+3.
//     wr_data[95:64]=DEADBEEF, remaining bytes 0x11, st_done at T+3.
//  3. SB addr=0x1F, data=0x000000AB, line=0 -> dmem_addr=0x1, wr_data[127:120]=AB, rest 0.
//  4. SH addr=0x0E, data=0x1234, line=all 0xFF -> wr_data[127:112]=1234, rest FF.
//  5. SH addr=0x03, and separately SW addr=0x06 -> ERR at T+1: st_done=st_misaligned=1,
//     rd_en/wr_en never asserted, st_ready=1 at T+2.
//  6. rst pulsed during MRG -> no wr_en at any later cycle, IDLE, st_ready=1.
//     Then st_valid pulsed while in RD -> ignored, exactly one write observed.

Source files
------------

// File: rtl/u_lsu_store_rmw_unit.sv
// Store read-modify-write unit: merges SB/SH/SW data into a 128-bit Dmem line
// that has no byte enables, one store at a time.
module u_lsu_store_rmw_unit #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic              sb,
  input  logic              sh,
  input  logic              sw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              dmem_rd_en,
  output logic [ADDR_W-5:0] dmem_addr,
  input  logic [LINE_W-1:0] dmem_rd_data,
  output logic              dmem_wr_en,
  output logic [LINE_W-1:0] dmem_wr_data,
  output logic              st_done,
  output logic              st_misaligned
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StMrg,
    StWr,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                sb_q, sh_q, sw_q;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          flag_cnt;
  logic                fault;
  logic                accept;

  assign accept = (state_q == StIdle) && st_valid;

  always_comb begin
    flag_cnt = {1'b0, sb} + {1'b0, sh} + {1'b0, sw};
    fault    = (flag_cnt != 2'd1) | (sh & addr[0]) | (sw & (addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (st_valid) state_d = fault ? StErr : StRd;
      StRd:    state_d = StMrg;
      StMrg:   state_d = StWr;
      StWr:    state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Only correctly sized, aligned stores reach MRG, so at most one flag is set here.
  always_comb begin
    line_d = dmem_rd_data;
    if (sb_q) begin
      line_d[{addr_q[3:0], 3'b000} +: 8] = data_q[7:0];
    end else if (sh_q) begin
      line_d[{addr_q[3:1], 4'b0000} +: 16] = data_q[15:0];
    end else if (sw_q) begin
      line_d[{addr_q[3:2], 5'b00000} +: 32] = data_q[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      sb_q    <= 1'b0;
      sh_q    <= 1'b0;
      sw_q    <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= addr;
        data_q <= st_data;
        sb_q   <= sb;
        sh_q   <= sh;
        sw_q   <= sw;
      end
      if (state_q == StMrg) begin
        line_q <= line_d;
      end
    end
  end

  always_comb begin
    st_ready      = (state_q == StIdle);
    dmem_rd_en    = (state_q == StRd);
    dmem_wr_en    = (state_q == StWr);
    st_done       = (state_q == StWr) || (state_q == StErr);
    st_misaligned = (state_q == StErr);
    dmem_addr     = '0;
    dmem_wr_data  = '0;
    if ((state_q == StRd) || (state_q == StMrg) || (state_q == StWr)) begin
      dmem_addr = addr_q[ADDR_W-1:4];
    end
    if (state_q == StWr) begin
      dmem_wr_data = line_q;
    end
  end

endmodule

// File: tb/tb_u_lsu_store_rmw_unit.sv
// Bench for u_lsu_store_rmw_unit: Dmem responder, byte-level reference model,
// per-cycle output compare, directed cases and randomized traffic.
module tb_u_lsu_store_rmw_unit;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid, st_ready;
  logic          sb, sh, sw;
  logic [AW-1:0] addr;
  logic [31:0]   st_data;
  logic          dmem_rd_en, dmem_wr_en;
  logic [AW-5:0] dmem_addr;
  logic [127:0]  dmem_rd_data, dmem_wr_data;
  logic          st_done, st_misaligned;

  always #5 clk = ~clk;

  u_lsu_store_rmw_unit #(
    .ADDR_W(AW),
    .LINE_W(128),
    .DATA_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .sb           (sb),
    .sh           (sh),
    .sw           (sw),
    .addr         (addr),
    .st_data      (st_data),
    .dmem_rd_en   (dmem_rd_en),
    .dmem_addr    (dmem_addr),
    .dmem_rd_data (dmem_rd_data),
    .dmem_wr_en   (dmem_wr_en),
    .dmem_wr_data (dmem_wr_data),
    .st_done      (st_done),
    .st_misaligned(st_misaligned)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Dmem responder: 16 lines, read data valid the cycle after rd_en, garbage otherwise.
  logic [127:0] mem [16];
  logic [127:0] ref_mem [16];
  logic         rd_pend, wr_pend;
  logic [3:0]   rd_a, wr_a;
  logic [127:0] wr_d;

  always @(negedge clk) begin
    rd_pend = dmem_rd_en;
    rd_a    = dmem_addr[3:0];
    wr_pend = dmem_wr_en;
    wr_a    = dmem_addr[3:0];
    wr_d    = dmem_wr_data;
  end

  always @(posedge clk) begin
    #1;
    if (wr_pend === 1'b1) mem[wr_a] = wr_d;
    if (rd_pend === 1'b1) dmem_rd_data = mem[rd_a];
    else dmem_rd_data = {$urandom, $urandom, $urandom, $urandom};
  end

  // Reference model: cycles elapsed since acceptance, and the line each store must produce.
  int           m_off = 0;
  bit           m_fault = 0;
  bit           m_init = 0;
  logic [11:0]  m_la = '0;
  logic [127:0] m_line = '0;

  function automatic logic [127:0] merge(input logic [127:0] line, input int a, input int n,
                                         input logic [31:0] d);
    for (int i = 0; i < n; i++) line[8*(a+i) +: 8] = d[8*i +: 8];
    return line;
  endfunction

  always @(posedge clk) begin
    int cnt, sz;
    bit f;
    if (m_init && m_off == 3) ref_mem[m_la[3:0]] = m_line;
    if (rst) begin
      m_init  = 1;
      m_off   = 0;
      m_fault = 0;
    end else if (m_init) begin
      if (m_off == 0) begin
        if (st_valid) begin
          cnt = int'(sb) + int'(sh) + int'(sw);
          sz  = sb ? 1 : (sh ? 2 : 4);
          f   = (cnt != 1) || ((int'(addr) % sz) != 0);
          m_la    = addr[15:4];
          m_fault = f;
          if (!f) m_line = merge(ref_mem[addr[7:4]], int'(addr[3:0]), sz, st_data);
          m_off = 1;
        end
      end else if (m_fault || m_off == 3) begin
        m_off = 0;
      end else begin
        m_off++;
      end
    end
  end

  int wr_count = 0;

  always @(negedge clk) begin
    if (m_init) begin
      chk("st_ready", st_ready, m_off == 0);
      chk("rd_en", dmem_rd_en, m_off == 1 && !m_fault);
      chk("wr_en", dmem_wr_en, m_off == 3);
      chk("st_done", st_done, m_off == 3 || (m_off == 1 && m_fault));
      chk("misaligned", st_misaligned, m_off == 1 && m_fault);
      chk("dmem_addr", dmem_addr, (!m_fault && m_off >= 1) ? m_la : 12'h0);
      chk("wr_data", dmem_wr_data, (m_off == 3) ? m_line : 128'h0);
      if (dmem_wr_en === 1'b1) wr_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic preload(input int l, input logic [127:0] v);
    mem[l]     = v;
    ref_mem[l] = v;
  endtask

  task automatic issue(input logic b, input logic h, input logic w, input logic [15:0] a,
                       input logic [31:0] d);
    st_valid = 1'b1;
    sb = b;
    sh = h;
    sw = w;
    addr = a;
    st_data = d;
    step();
    st_valid = 1'b0;
  endtask

  initial begin
    int wc;
    int r;
    int sz;
    rst = 1'b1;
    st_valid = 1'b0;
    sb = 1'b0;
    sh = 1'b0;
    sw = 1'b0;
    addr = '0;
    st_data = '0;
    for (int i = 0; i < 16; i++) preload(i, {$urandom, $urandom, $urandom, $urandom});
    idle(2);
    rst = 1'b0;
    step();

    preload(0, {16{8'h11}});
    issue(1'b0, 1'b0, 1'b1, 16'h0008, 32'hDEADBEEF);
    idle(5);
    chk("sw_line", mem[0], 128'h11111111_DEADBEEF_11111111_11111111);
    chk("sw_model", ref_mem[0], 128'h11111111_DEADBEEF_11111111_11111111);

    preload(1, 128'h0);
    issue(1'b1, 1'b0, 1'b0, 16'h001F, 32'h000000AB);
    idle(5);
    chk("sb_line", mem[1], {8'hAB, 120'h0});
    chk("sb_model", ref_mem[1], {8'hAB, 120'h0});

    preload(0, {16{8'hFF}});
    issue(1'b0, 1'b1, 1'b0, 16'h000E, 32'h00001234);
    idle(5);
    chk("sh_line", mem[0], {16'h1234, {112{1'b1}}});
    chk("sh_model", ref_mem[0], {16'h1234, {112{1'b1}}});

    wc = wr_count;
    issue(1'b0, 1'b1, 1'b0, 16'h0003, 32'h0000BEEF);
    idle(3);
    issue(1'b0, 1'b0, 1'b1, 16'h0006, 32'hCAFEF00D);
    idle(3);
    chk("fault_no_write", wr_count - wc, 0);

    wc = wr_count;
    issue(1'b0, 1'b0, 1'b1, 16'h0024, 32'h01234567);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(6);
    chk("abort_no_write", wr_count - wc, 0);

    wc = wr_count;
    issue(1'b1, 1'b0, 1'b0, 16'h0031, 32'h0000005A);
    st_valid = 1'b1;
    addr = 16'h0042;
    step();
    st_valid = 1'b0;
    idle(5);
    chk("rd_valid_ignored", wr_count - wc, 1);

    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      st_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      sb = (r <= 2);
      sh = (r >= 3 && r <= 5);
      sw = (r >= 6 && r <= 8);
      if (r == 9) {sb, sh, sw} = 3'($urandom_range(0, 7));
      sz = sh ? 2 : (sw ? 4 : 1);
      addr = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~16'(sz - 1);
      st_data = $urandom;
      step();
    end
    rst = 1'b0;
    st_valid = 1'b0;
    idle(6);
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
